alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Initiator-side sequencer for the GF(2^m) polynomial ALU of the Niederreiter cryptoprocessor. Accepts one ALU command at a time from instruction decode over a valid/ready handshake. Drives the ALU operand-load strobes, operand data and opcode, then waits for `compute_done`. Captures both result words and returns them to the register file over a second valid/ready handshake.

## Interface
- `ISSUE_CYC`, 1: cycles the load strobes stay high (1..3; 2 required for div/mul back-to-back use).
- `TMO_CYC`, 1023: watchdog limit in WAIT, in cycles (`TIMEOUT` build only).
- `clk`  in  1  system clock
- `rst_b`  in  1  synchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  issuer can accept; high only in IDLE
- `cmd_op`  in  4  ALU opcode
- `cmd_o`  in  145  operand O
- `cmd_t`  in  144  operand T
- `cmd_mod`  in  145  modulus polynomial
- `cmd_mod_ld`  in  1  also load modulus with this command
- `alu_o_sel`, `alu_t_sel`, `alu_mod_sel`  out  1 each  ALU load strobes
- `alu_o_dat`  out  145; `alu_t_dat`  out  144; `alu_mod_dat`  out  145  ALU operands
- `alu_typ_sel`  out  4  ALU opcode
- `compute_done`  in  1  ALU completion
- `alu_r_dat1`, `alu_r_dat2`  in  144 each  ALU results
- `res_valid`  out  1  result held
- `res_ready`  in  1  consumer accepts
- `res_dat1`, `res_dat2`  out  144 each  captured results
- `res_err`  out  1  result invalid (timeout); qualified by `res_valid`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid&cmd_ready`, register op/O/T/mod/mod_ld → ISSUE, issue counter cleared.
- ISSUE: `alu_o_sel`=`alu_t_sel`=1, `alu_mod_sel`=mod_ld, for exactly `ISSUE_CYC` cycles → WAIT.
- WAIT: strobes 0; `alu_typ_sel`, `alu_*_dat` held. On first cycle `compute_done`=1, capture `alu_r_dat1/2` → RESP, `res_err`=0.
- `compute_done` is ignored during ISSUE and the first WAIT cycle. This rejects stale done from the previous op.
- RESP: `res_valid`=1; outputs stable until `res_ready`. On `res_ready` → IDLE.
- Opcodes pass through unchecked: 0001 add, 0010 split, 0011 mul, 0101 div, 0111 deg, 1000 shift, 1001 eval. All complete via `compute_done`.
- `alu_typ_sel`=0000 in IDLE and RESP. Operand outputs keep their last-issued values.
- Modulus persists in the ALU. The issuer drives `alu_mod_dat` from its register, updated only when mod_ld=1.
- Reset mid-operation: state→IDLE at next edge; command discarded; no result produced.

## Timing
- Reset values: `cmd_ready`=1 after reset edge, every other output 0 (all data buses zero).
- Accept at edge 0 → strobes high cycles 1..`ISSUE_CYC` → WAIT from cycle `ISSUE_CYC`+1.
- Done sampled at edge k → `res_valid` high from cycle k+1. Latency = ALU time + 2.
- `res_valid`&`res_ready` at edge r → `cmd_ready` high cycle r+1. Minimum command spacing is `ISSUE_CYC`+4 cycles.
- `res_ready` high before `res_valid`: no effect.
- Opcode and operands stable from cycle 1 until leaving WAIT.

## Configuration
- `ALU_ISSUER_TIMEOUT_EN` defined: the watchdog counts WAIT cycles. At `TMO_CYC` without done → RESP with `res_err`=1, `res_dat1/2`=0.
- `ALU_ISSUER_TIMEOUT_EN` undefined: WAIT is unbounded; `res_err` is tied 0; no counter logic.

## Structure
- Package `niederreiter_alu_pkg`: `DAT_W`=144, `LDAT_W`=145, opcode constants, state enum.
- Sub-module `alu_watchdog`: load/clear/expire counter, instantiated only under `ALU_ISSUER_TIMEOUT_EN`.

## Test plan
- Add: O=0xfff1, T=0x0f0f, op 0001, ALU model done after 1 cycle → strobes high 1 cycle, `res_dat1`=0xf0fe, `res_valid` 3 cycles after the strobe.
- Mul with mod_ld=1, then eval with mod_ld=0 → `alu_mod_sel` pulses on the first command only; `alu_mod_dat` unchanged on the second.
- `ISSUE_CYC`=2, div op 0101 → strobes high exactly 2 cycles; done held high from the previous op is ignored until WAIT cycle 2.
- Backpressure: `res_ready` low 5 cycles → `res_dat1/2` and `res_valid` stable; `cmd_ready` stays 0; new `cmd_valid` not accepted.
- Timeout build, `TMO_CYC`=16, no done → `res_valid`=1, `res_err`=1, data 0 at WAIT cycle 16.
- `rst_b` low during WAIT → next cycle IDLE, `cmd_ready`=1, strobes 0, `alu_typ_sel`=0, no `res_valid`.

Source files
------------

// File: rtl/niederreiter_alu_pkg.sv
// -----------------------------------------------------------------------------
// niederreiter_alu_pkg
// Shared definitions for the GF(2^m) polynomial ALU command path of the
// Niederreiter cryptoprocessor. The file has no ports. It provides:
//   DAT_W / LDAT_W  - result/operand widths (144 and 145 bits)
//   alu_op_t, OP_*  - ALU opcode encodings driven on alu_typ_sel
//   iss_state_e     - sequencer states of alu_cmd_issuer
// -----------------------------------------------------------------------------
package niederreiter_alu_pkg;

    localparam int DAT_W  = 144;
    localparam int LDAT_W = 145;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_NONE  = 4'b0000;
    localparam alu_op_t OP_ADD   = 4'b0001;
    localparam alu_op_t OP_SPLIT = 4'b0010;
    localparam alu_op_t OP_MUL   = 4'b0011;
    localparam alu_op_t OP_DIV   = 4'b0101;
    localparam alu_op_t OP_DEG   = 4'b0111;
    localparam alu_op_t OP_SHIFT = 4'b1000;
    localparam alu_op_t OP_EVAL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } iss_state_e;

endpackage

// File: rtl/alu_watchdog.sv
// -----------------------------------------------------------------------------
// alu_watchdog
// Counts cycles while enabled and flags expiry on the TMO_CYC-th enabled
// cycle. Used by alu_cmd_issuer only when ALU_ISSUER_TIMEOUT_EN is defined.
// Ports:
//   clk       in   system clock
//   rst_b     in   synchronous active-low reset
//   clr_i     in   load the count with zero (takes priority over counting)
//   en_i      in   count this cycle
//   expire_o  out  high during the TMO_CYC-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module alu_watchdog #(
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count saturates at the last value so expiry stays asserted if the
    // owner keeps the counter enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
// Initiator-side sequencer for the GF(2^m) polynomial ALU. Accepts one
// command from decode (valid/ready), strobes the operands into the ALU for
// ISSUE_CYC cycles, waits for compute_done, captures both result words and
// hands them to the register file (valid/ready).
//
// Optional build macro: ALU_ISSUER_TIMEOUT_EN
//   defined   - WAIT is bounded by TMO_CYC cycles; expiry returns a response
//               with res_err=1 and zero data.
//   undefined - WAIT is unbounded; res_err is tied low.
//
// Ports:
//   clk, rst_b                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only in IDLE)
//   cmd_op, cmd_o, cmd_t, cmd_mod      opcode, operands, modulus
//   cmd_mod_ld                         also load the modulus with this command
//   alu_o_sel/alu_t_sel/alu_mod_sel    ALU operand load strobes
//   alu_o_dat/alu_t_dat/alu_mod_dat    ALU operand buses (held between ops)
//   alu_typ_sel                        ALU opcode (0 in IDLE and RESP)
//   compute_done, alu_r_dat1/2         ALU completion and results
//   res_valid/res_ready                result handshake
//   res_dat1/2, res_err                captured results, timeout flag
// -----------------------------------------------------------------------------
module alu_cmd_issuer
    import niederreiter_alu_pkg::*;
#(
    parameter int unsigned ISSUE_CYC = 1,
    parameter int unsigned TMO_CYC   = 1023
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [LDAT_W-1:0] cmd_o,
    input  logic [DAT_W-1:0]  cmd_t,
    input  logic [LDAT_W-1:0] cmd_mod,
    input  logic              cmd_mod_ld,
    output logic              alu_o_sel,
    output logic              alu_t_sel,
    output logic              alu_mod_sel,
    output logic [LDAT_W-1:0] alu_o_dat,
    output logic [DAT_W-1:0]  alu_t_dat,
    output logic [LDAT_W-1:0] alu_mod_dat,
    output logic [3:0]        alu_typ_sel,
    input  logic              compute_done,
    input  logic [DAT_W-1:0]  alu_r_dat1,
    input  logic [DAT_W-1:0]  alu_r_dat2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DAT_W-1:0]  res_dat1,
    output logic [DAT_W-1:0]  res_dat2,
    output logic              res_err
);

    localparam logic [1:0] ISS_LAST = 2'(ISSUE_CYC - 1);

    iss_state_e        state_q;
    iss_state_e        state_d;

    alu_op_t           op_q;
    logic [LDAT_W-1:0] o_q;
    logic [DAT_W-1:0]  t_q;
    logic [LDAT_W-1:0] mod_q;
    logic              mod_ld_q;
    logic [1:0]        iss_cnt_q;
    logic              wait_arm_q;
    logic [DAT_W-1:0]  r1_q;
    logic [DAT_W-1:0]  r2_q;

    logic              accept;
    logic              done_ok;
    logic              tmo_expire;

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    // wait_arm_q is low during the first WAIT cycle, so a done level left
    // over from the previous operation cannot complete this one.
    assign done_ok = (state_q == ST_WAIT) && wait_arm_q && compute_done;

`ifdef ALU_ISSUER_TIMEOUT_EN
    logic err_q;

    alu_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_b    (rst_b),
        .clr_i    (state_q != ST_WAIT),
        .en_i     (state_q == ST_WAIT),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            err_q <= 1'b0;
        end else if (done_ok) begin
            err_q <= 1'b0;
        end else if (tmo_expire) begin
            err_q <= 1'b1;
        end
    end

    assign res_err = err_q;
`else
    logic unused_tmo_cfg;

    assign tmo_expire     = 1'b0;
    assign res_err        = 1'b0;
    assign unused_tmo_cfg = (TMO_CYC != 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (iss_cnt_q == ISS_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_ok || tmo_expire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        cmd_ready   = 1'b0;
        alu_o_sel   = 1'b0;
        alu_t_sel   = 1'b0;
        alu_mod_sel = 1'b0;
        alu_typ_sel = OP_NONE;
        res_valid   = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_ISSUE: begin
                alu_o_sel   = 1'b1;
                alu_t_sel   = 1'b1;
                alu_mod_sel = mod_ld_q;
                alu_typ_sel = op_q;
            end
            ST_WAIT: alu_typ_sel = op_q;
            ST_RESP: res_valid = 1'b1;
            default: ;
        endcase
    end

    // Command, issue-timing and result registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            op_q       <= OP_NONE;
            o_q        <= '0;
            t_q        <= '0;
            mod_q      <= '0;
            mod_ld_q   <= 1'b0;
            iss_cnt_q  <= '0;
            wait_arm_q <= 1'b0;
            r1_q       <= '0;
            r2_q       <= '0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                o_q      <= cmd_o;
                t_q      <= cmd_t;
                mod_ld_q <= cmd_mod_ld;
                // The ALU keeps its modulus, so the bus only changes when
                // a new modulus is actually loaded.
                if (cmd_mod_ld) begin
                    mod_q <= cmd_mod;
                end
            end

            iss_cnt_q  <= (state_q == ST_ISSUE) ? iss_cnt_q + 2'd1 : 2'd0;
            wait_arm_q <= (state_q == ST_WAIT);

            if (done_ok) begin
                r1_q <= alu_r_dat1;
                r2_q <= alu_r_dat2;
            end else if (tmo_expire) begin
                r1_q <= '0;
                r2_q <= '0;
            end
        end
    end

    assign alu_o_dat   = o_q;
    assign alu_t_dat   = t_q;
    assign alu_mod_dat = mod_q;
    assign res_dat1    = r1_q;
    assign res_dat2    = r2_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Self-checking bench for alu_cmd_issuer. The bench plays both the
// instruction decoder and a behavioural ALU whose results are a fixed
// function of the operands it was loaded with. Expected responses come from
// the same function applied to the command the bench issued, plus the
// handshake timing rules. Timeout checks run when ALU_ISSUER_TIMEOUT_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;
    import niederreiter_alu_pkg::*;

    localparam int ISSUE_CYC = 2;
    localparam int TMO_CYC   = 16;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = '0;
    logic [LDAT_W-1:0] cmd_o = '0;
    logic [DAT_W-1:0]  cmd_t = '0;
    logic [LDAT_W-1:0] cmd_mod = '0;
    logic              cmd_mod_ld = 1'b0;
    logic              alu_o_sel, alu_t_sel, alu_mod_sel;
    logic [LDAT_W-1:0] alu_o_dat, alu_mod_dat;
    logic [DAT_W-1:0]  alu_t_dat;
    logic [3:0]        alu_typ_sel;
    logic              compute_done = 1'b0;
    logic [DAT_W-1:0]  alu_r_dat1 = '0;
    logic [DAT_W-1:0]  alu_r_dat2 = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DAT_W-1:0]  res_dat1, res_dat2;
    logic              res_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [LDAT_W-1:0] cur_mod = '0;      // modulus the issuer should be driving
    logic [LDAT_W-1:0] alu_mod_mdl = '0;  // modulus held inside the model ALU

    alu_cmd_issuer #(
        .ISSUE_CYC (ISSUE_CYC),
        .TMO_CYC   (TMO_CYC)
    ) u_dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_o        (cmd_o),
        .cmd_t        (cmd_t),
        .cmd_mod      (cmd_mod),
        .cmd_mod_ld   (cmd_mod_ld),
        .alu_o_sel    (alu_o_sel),
        .alu_t_sel    (alu_t_sel),
        .alu_mod_sel  (alu_mod_sel),
        .alu_o_dat    (alu_o_dat),
        .alu_t_dat    (alu_t_dat),
        .alu_mod_dat  (alu_mod_dat),
        .alu_typ_sel  (alu_typ_sel),
        .compute_done (compute_done),
        .alu_r_dat1   (alu_r_dat1),
        .alu_r_dat2   (alu_r_dat2),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_dat1     (res_dat1),
        .res_dat2     (res_dat2),
        .res_err      (res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LDAT_W-1:0] obs,
                         input logic [LDAT_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LDAT_W-1:0] rnd_w();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[LDAT_W-1:0];
    endfunction

    // Model ALU: result 1 is the GF(2)[x] sum O+T (bitwise XOR); result 2
    // mixes halves of the operands with the held modulus and the opcode so
    // every input bus influences the response.
    function automatic logic [2*DAT_W-1:0] alu_ref(input logic [3:0] op,
            input logic [LDAT_W-1:0] o, input logic [DAT_W-1:0] t,
            input logic [LDAT_W-1:0] m);
        logic [DAT_W-1:0] r1, r2;
        r1 = o[DAT_W-1:0] ^ t;
        r2 = {t[71:0], o[143:72]} ^ m[DAT_W-1:0] ^ {{(DAT_W-4){1'b0}}, op};
        return {r1, r2};
    endfunction

    // Issues one command starting at a negedge in IDLE and returns at a
    // negedge back in IDLE. lat = cycles between the first WAIT cycle and
    // done (0 = ALU never answers), stale = done held high through ISSUE and
    // the first WAIT cycle, bp = cycles of res_ready low, early = res_ready
    // raised already during WAIT.
    task automatic run_cmd(input logic [3:0] op, input logic [LDAT_W-1:0] o,
            input logic [DAT_W-1:0] t, input logic [LDAT_W-1:0] md,
            input bit mld, input int lat, input bit stale, input int bp,
            input bit early);
        logic [2*DAT_W-1:0] exp_r;
        logic [DAT_W-1:0]   e1, e2;
        logic [LDAT_W-1:0]  ao;
        logic [DAT_W-1:0]   at;
        logic [3:0]         aop;
        int c, s_cnt, m_cnt, s_end, rv_cyc, exp_rv;
        bit exp_err;

        if (mld) cur_mod = md;
        exp_r = alu_ref(op, o, t, cur_mod);
        if (lat > 0) begin
            e1 = exp_r[2*DAT_W-1:DAT_W];
            e2 = exp_r[DAT_W-1:0];
            exp_err = 1'b0;
            exp_rv  = ISSUE_CYC + lat + 2;
        end else begin
            e1 = '0;
            e2 = '0;
            exp_err = 1'b1;
            exp_rv  = ISSUE_CYC + TMO_CYC + 1;
        end

        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_o = o; cmd_t = t;
        cmd_mod = md; cmd_mod_ld = mld;
        compute_done = stale;
        alu_r_dat1 = rnd_w(); alu_r_dat2 = rnd_w();
        res_ready = 1'b0;
        @(negedge clk);
        // Accepted at the previous edge; the inputs must no longer matter.
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_o = rnd_w();
        cmd_t = DAT_W'(rnd_w()); cmd_mod = rnd_w(); cmd_mod_ld = 1'($urandom);

        ao = '0; at = '0; aop = '0;
        c = 1; s_cnt = 0; m_cnt = 0; s_end = 0; rv_cyc = 0;
        while (rv_cyc == 0 && c < 400) begin
            if (res_valid) begin
                rv_cyc = c;
            end else begin
                check("typ_sel_busy", alu_typ_sel, op);
                check("o_dat_busy", alu_o_dat, o);
                check("t_dat_busy", alu_t_dat, t);
                check("mod_dat_busy", alu_mod_dat, cur_mod);
                check("cmd_ready_busy", cmd_ready, 1'b0);
                check("t_sel_eq_o_sel", alu_t_sel, alu_o_sel);
                if (alu_o_sel) begin
                    s_cnt++; s_end = c;
                    ao = alu_o_dat; at = alu_t_dat; aop = alu_typ_sel;
                end
                if (alu_mod_sel) begin
                    m_cnt++;
                    alu_mod_mdl = alu_mod_dat;
                end
                compute_done = 1'b0;
                alu_r_dat1 = DAT_W'(rnd_w()); alu_r_dat2 = DAT_W'(rnd_w());
                if (alu_o_sel || (s_end > 0 && c == s_end + 1)) begin
                    compute_done = stale;
                end else if (lat > 0 && s_end > 0 && c == s_end + 1 + lat) begin
                    {alu_r_dat1, alu_r_dat2} = alu_ref(aop, ao, at, alu_mod_mdl);
                    compute_done = 1'b1;
                end
                res_ready = early;
                @(negedge clk);
                c++;
            end
        end
        compute_done = 1'b0;

        check("res_valid_seen", rv_cyc != 0, 1'b1);
        check("res_latency", LDAT_W'(rv_cyc), LDAT_W'(exp_rv));
        check("strobe_cycles", LDAT_W'(s_cnt), LDAT_W'(ISSUE_CYC));
        check("strobe_first_cycle", LDAT_W'(s_end - s_cnt + 1), LDAT_W'(1));
        check("mod_strobe_cycles", LDAT_W'(m_cnt), mld ? LDAT_W'(ISSUE_CYC) : '0);

        for (int i = 0; i <= bp; i++) begin
            check("res_valid_hold", res_valid, 1'b1);
            check("res_dat1", res_dat1, e1);
            check("res_dat2", res_dat2, e2);
            check("res_err", res_err, exp_err);
            check("typ_sel_resp", alu_typ_sel, OP_NONE);
            check("cmd_ready_resp", cmd_ready, 1'b0);
            check("strobes_resp", {alu_o_sel, alu_t_sel, alu_mod_sel}, '0);
            check("o_dat_held", alu_o_dat, o);
            check("mod_dat_held", alu_mod_dat, cur_mod);
            if (i == bp) begin
                cmd_valid = 1'b0;
                res_ready = 1'b1;
            end else begin
                res_ready = 1'b0;
                cmd_valid = 1'b1; cmd_op = 4'($urandom); cmd_o = rnd_w();
                cmd_mod = rnd_w(); cmd_mod_ld = 1'b1;
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        check("res_valid_after_ack", res_valid, 1'b0);
        check("cmd_ready_after_ack", cmd_ready, 1'b1);
        check("typ_sel_idle", alu_typ_sel, OP_NONE);
        check("strobes_idle", {alu_o_sel, alu_t_sel, alu_mod_sel}, '0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_strobes"}, {alu_o_sel, alu_t_sel, alu_mod_sel}, '0);
        check({tag, "_typ_sel"}, alu_typ_sel, '0);
        check({tag, "_o_dat"}, alu_o_dat, '0);
        check({tag, "_t_dat"}, alu_t_dat, '0);
        check({tag, "_mod_dat"}, alu_mod_dat, '0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_dat1"}, res_dat1, '0);
        check({tag, "_res_dat2"}, res_dat2, '0);
        check({tag, "_res_err"}, res_err, 1'b0);
    endtask

    task automatic reset_mid_op();
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_o = rnd_w();
        cmd_t = DAT_W'(rnd_w()); cmd_mod = rnd_w(); cmd_mod_ld = 1'b1;
        compute_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (ISSUE_CYC + 1) @(negedge clk);
        check("wait_before_reset_ready", cmd_ready, 1'b0);
        check("wait_before_reset_valid", res_valid, 1'b0);
        rst_b = 1'b0;
        compute_done = 1'b1;
        @(negedge clk);
        rst_b = 1'b1;
        cur_mod = '0;
        check_reset_state("mid_reset");
        for (int i = 0; i < 5; i++) begin
            compute_done = 1'($urandom);
            @(negedge clk);
            check("no_result_after_reset", res_valid, 1'b0);
            check("idle_after_reset", cmd_ready, 1'b1);
        end
        compute_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [7];
        int lat, bp;
        bit early, stale, mld;
        ops = '{OP_ADD, OP_SPLIT, OP_MUL, OP_DIV, OP_DEG, OP_SHIFT, OP_EVAL};

        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_b = 1'b1;
        @(negedge clk);

        // Add: 0xfff1 + 0x0f0f = 0xf0fe in GF(2)[x], ALU answers 1 cycle late.
        run_cmd(OP_ADD, 145'hfff1, 144'h0f0f, '0, 1'b0, 1, 1'b0, 0, 1'b0);
        check("add_res_dat1_const", res_dat1, 145'hf0fe);

        // Modulus loaded with mul, then reused by eval without reload.
        run_cmd(OP_MUL, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b1, 3, 1'b0, 0, 1'b0);
        run_cmd(OP_EVAL, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b0, 2, 1'b0, 0, 1'b0);

        // Done still high from the previous op must be ignored.
        run_cmd(OP_DIV, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b0, 1, 1'b1, 0, 1'b0);

        // Result backpressure for 5 cycles.
        run_cmd(OP_SHIFT, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b1, 2, 1'b0, 5, 1'b0);

        // res_ready already high before res_valid.
        run_cmd(OP_DEG, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b0, 4, 1'b0, 0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            lat   = $urandom_range(1, 6);
            bp    = $urandom_range(0, 3);
            early = (bp == 0) && ($urandom_range(0, 1) == 1);
            stale = 1'($urandom);
            mld   = 1'($urandom);
            run_cmd(ops[$urandom_range(0, 6)], rnd_w(), DAT_W'(rnd_w()), rnd_w(),
                    mld, lat, stale, bp, early);
        end

        reset_mid_op();
        run_cmd(OP_MUL, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b1, 2, 1'b0, 1, 1'b0);

`ifdef ALU_ISSUER_TIMEOUT_EN
        run_cmd(OP_DIV, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b0, 0, 1'b0, 2, 1'b0);
        run_cmd(OP_ADD, rnd_w(), DAT_W'(rnd_w()), rnd_w(), 1'b0, 3, 1'b1, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
